// File: rtl/ip_fifo_push_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ip_fifo_arb_pkg
// Purpose  : FSM state type and width helper for the FIFO push/pop schedulers.
// Revision : 1.0
// ============================================================================
package ip_fifo_arb_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

    // ceil(log2(value)), but never narrower than one bit
    function automatic int clog2_min1(input int value);
        int w;
        w = 1;
        while ((1 << w) < value) begin
            w++;
        end
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ip_fifo_push_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : ip_fifo_push_arbiter_if
// Purpose  : Requester handshake, FIFO push port and status bundle.
// Revision : 1.0
// ============================================================================
interface ip_fifo_push_arbiter_if
    import ip_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int FIFO_WIDTH = 32
) ();

    localparam int c_IDX_W = clog2_min1(NUM_REQ);

    logic [NUM_REQ-1:0]            reqValid;
    logic [NUM_REQ*FIFO_WIDTH-1:0] reqData;
    logic [NUM_REQ-1:0]            reqLast;
    logic [NUM_REQ-1:0]            reqReady;
    logic                          fifoFull;
    logic                          fifoPush;
    logic [FIFO_WIDTH-1:0]         fifoData;
    logic [c_IDX_W-1:0]            grantId;
    logic                          busy;
    logic [NUM_REQ-1:0]            starveErr;

    modport slave (
        input  reqValid, reqData, reqLast, fifoFull,
        output reqReady, fifoPush, fifoData, grantId, busy, starveErr
    );

    modport master (
        output reqValid, reqData, reqLast, fifoFull,
        input  reqReady, fifoPush, fifoData, grantId, busy, starveErr
    );

endinterface
`default_nettype wire

// File: rtl/ip_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : ip_rr_pick
// Purpose  : Combinational round-robin picker: first request above i_last.
// Revision : 1.0
// ============================================================================
module ip_rr_pick
    import ip_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = clog2_min1(NUM_REQ)
) (
    input  wire logic [NUM_REQ-1:0] i_req,
    input  wire logic [IDX_W-1:0]   i_last,
    output logic      [IDX_W-1:0]   o_idx,
    output logic                    o_any
);

    logic [IDX_W-1:0] w_cand;

    // Scan from the farthest offset down so the nearest one wins.
    always_comb begin
        o_idx  = '0;
        o_any  = |i_req;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = IDX_W'((int'(i_last) + k) % NUM_REQ);
            if (i_req[w_cand]) begin
                o_idx = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ip_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ip_fifo_push_arbiter
// Purpose  : Round-robin burst arbiter for an async FIFO write port.
//            Optional starvation counters: IP_FIFO_ARB_STARVE_EN.
// Revision : 1.0
// ============================================================================
module ip_fifo_push_arbiter
    import ip_fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = 4,
    parameter int FIFO_WIDTH   = 32,
    parameter int MAX_BURST    = 8,
    parameter int STARVE_LIMIT = 64
) (
    input  wire logic       clock,
    input  wire logic       reset,
    ip_fifo_push_arbiter_if.slave arb
);

    localparam int c_IDX_W  = clog2_min1(NUM_REQ);
    localparam int c_BEAT_W = clog2_min1(MAX_BURST);
    localparam logic [c_BEAT_W-1:0] c_BEAT_LAST = c_BEAT_W'(MAX_BURST - 1);

    arb_state_t            r_state;
    arb_state_t            w_state_nxt;
    logic [c_IDX_W-1:0]    r_grant;
    logic [c_IDX_W-1:0]    r_last_grant;
    logic [c_IDX_W-1:0]    w_pick;
    logic                  w_any;
    logic [c_BEAT_W-1:0]   r_beat_cnt;
    logic                  w_granted;
    logic                  w_xfer;
    logic                  w_release;
    logic [FIFO_WIDTH-1:0] w_sel_data;

    ip_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_IDX_W)
    ) u_pick (
        .i_req   (arb.reqValid),
        .i_last  (r_last_grant),
        .o_idx   (w_pick),
        .o_any   (w_any)
    );

    // Nothing is accepted while reset is high; the burst restarts afterwards.
    assign w_granted = (r_state == ST_GRANT) && !reset;
    assign w_xfer    = w_granted && !arb.fifoFull && arb.reqValid[r_grant];
    assign w_release = w_xfer && (arb.reqLast[r_grant] || (r_beat_cnt == c_BEAT_LAST));

    always_comb begin
        w_sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (r_grant == c_IDX_W'(i)) begin
                w_sel_data = arb.reqData[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        arb.reqReady = '0;
        arb.fifoPush = 1'b0;
        arb.fifoData = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (w_granted && !arb.fifoFull) begin
                    arb.reqReady[r_grant] = 1'b1;
                end
                if (w_xfer) begin
                    arb.fifoPush = 1'b1;
                    arb.fifoData = w_sel_data;
                end
                if (w_release) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_grant      <= '0;
            r_last_grant <= c_IDX_W'(NUM_REQ - 1);
            r_beat_cnt   <= '0;
        end else if (r_state == ST_IDLE) begin
            if (w_any) begin
                r_grant    <= w_pick;
                r_beat_cnt <= '0;
            end
        end else if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_release) begin
                r_last_grant <= r_grant;
            end
        end
    end

    assign arb.grantId = r_grant;
    assign arb.busy    = (r_state == ST_GRANT);

`ifdef IP_FIFO_ARB_STARVE_EN
    localparam int c_STARVE_W = clog2_min1(STARVE_LIMIT + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_LIMIT);

    logic [NUM_REQ-1:0] w_starve;

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_starve
        logic [c_STARVE_W-1:0] r_wait;
        logic [c_STARVE_W-1:0] w_wait_nxt;
        logic                  r_err;
        logic                  w_owner;
        logic                  w_win;

        assign w_owner = (r_state == ST_GRANT) && (r_grant == c_IDX_W'(gi));
        assign w_win   = (r_state == ST_IDLE) && w_any && (w_pick == c_IDX_W'(gi));

        always_comb begin
            w_wait_nxt = r_wait;
            if (w_win) begin
                w_wait_nxt = '0;
            end else if (arb.reqValid[gi] && !w_owner && (r_wait != c_STARVE_MAX)) begin
                w_wait_nxt = r_wait + 1'b1;
            end
        end

        // Flag on the same edge the counter saturates.
        always_ff @(posedge clock) begin
            if (reset) begin
                r_wait <= '0;
                r_err  <= 1'b0;
            end else begin
                r_wait <= w_wait_nxt;
                if (w_wait_nxt == c_STARVE_MAX) begin
                    r_err <= 1'b1;
                end
            end
        end

        assign w_starve[gi] = r_err;
    end

    assign arb.starveErr = w_starve;
`else
    if (STARVE_LIMIT < 0) begin : g_starve_off
    end

    assign arb.starveErr = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ip_fifo_push_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ip_fifo_push_arbiter
// Purpose  : Self-checking bench: vector table, burst sequences, random model.
// Revision : 1.0
// ============================================================================
module tb_ip_fifo_push_arbiter;

    localparam int c_N      = 4;
    localparam int c_W      = 32;
    localparam int c_MAXB   = 4;
    localparam int c_STARVE = 16;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    ip_fifo_push_arbiter_if #(.NUM_REQ(c_N), .FIFO_WIDTH(c_W)) bus ();

    ip_fifo_push_arbiter #(
        .NUM_REQ      (c_N),
        .FIFO_WIDTH   (c_W),
        .MAX_BURST    (c_MAXB),
        .STARVE_LIMIT (c_STARVE)
    ) dut (
        .clock (clock),
        .reset (reset),
        .arb   (bus)
    );

    logic [c_W-1:0] dat [c_N];
    assign bus.reqData = {dat[3], dat[2], dat[1], dat[0]};

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [c_W-1:0] tag(input int r, input int n);
        return c_W'(32'hC0DE_0000 + r * 4096 + n);
    endfunction

    function automatic logic bit_of(input logic [c_N-1:0] v, input int i);
        return v[i[1:0]];
    endfunction

    task automatic do_reset();
        reset        = 1'b1;
        bus.reqValid = '0;
        bus.reqLast  = '0;
        bus.fifoFull = 1'b0;
        for (int i = 0; i < c_N; i++) dat[i] = '0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [3:0] valid;
        logic [3:0] last;
        logic       full;
        logic [3:0] ready;
        logic       push;
        logic       busy;
        int         gid;
    } vec_t;

    vec_t tbl [$];

    task automatic run_table();
        for (int r = 0; r < tbl.size(); r++) begin
            bus.reqValid = tbl[r].valid;
            bus.reqLast  = tbl[r].last;
            bus.fifoFull = tbl[r].full;
            for (int i = 0; i < c_N; i++) dat[i] = tag(i, r);
            @(negedge clock);
            check($sformatf("tbl%0d_ready", r), bus.reqReady, tbl[r].ready);
            check($sformatf("tbl%0d_push", r), bus.fifoPush, tbl[r].push);
            check($sformatf("tbl%0d_data", r), bus.fifoData,
                  tbl[r].push ? tag(tbl[r].gid, r) : '0);
            check($sformatf("tbl%0d_busy", r), bus.busy, tbl[r].busy);
            check($sformatf("tbl%0d_gid", r), bus.grantId, tbl[r].gid);
            @(posedge clock);
            #1;
        end
    endtask

    // ---------------- requester BFM sequences ----------------
    int total [c_N];
    int blen  [c_N];
    int sent  [c_N];

    task automatic run_bfm(input string nm, input int exp_g[$]);
        logic [c_N-1:0] v, l, hs;
        for (int c = 0; c < exp_g.size(); c++) begin
            v = '0;
            l = '0;
            for (int i = 0; i < c_N; i++) begin
                if (sent[i] < total[i]) v = v | (c_N'(1) << i);
                if ((sent[i] % blen[i] == blen[i] - 1) || (sent[i] == total[i] - 1))
                    l = l | (c_N'(1) << i);
                dat[i] = tag(i, sent[i]);
            end
            bus.reqValid = v;
            bus.reqLast  = l;
            @(negedge clock);
            check($sformatf("%s_c%0d_push", nm, c), bus.fifoPush, exp_g[c] >= 0);
            check($sformatf("%s_c%0d_busy", nm, c), bus.busy, exp_g[c] >= 0);
            if (exp_g[c] >= 0) begin
                check($sformatf("%s_c%0d_gid", nm, c), bus.grantId, exp_g[c]);
                check($sformatf("%s_c%0d_data", nm, c), bus.fifoData, tag(exp_g[c], sent[exp_g[c]]));
            end else begin
                check($sformatf("%s_c%0d_data", nm, c), bus.fifoData, 0);
            end
            hs = bus.reqReady & bus.reqValid;
            @(posedge clock);
            #1;
            for (int i = 0; i < c_N; i++) if (bit_of(hs, i)) sent[i]++;
        end
    endtask

    task automatic set_req(input int i, input int t, input int b);
        total[i] = t;
        blen[i]  = b;
        sent[i]  = 0;
    endtask

    // ---------------- random test against a burst-level model ----------------
    task automatic run_random(input int ncyc);
        int m_owner, m_last, m_gid, m_beats;
        logic [c_N-1:0] v, l, e_ready;
        logic f, e_push;
        logic [c_W-1:0] e_data;
        m_owner = -1;
        m_last  = c_N - 1;
        m_gid   = 0;
        m_beats = 0;
        for (int c = 0; c < ncyc; c++) begin
            v = c_N'($urandom);
            l = c_N'($urandom & $urandom);
            f = ($urandom % 4) == 0;
            bus.reqValid = v;
            bus.reqLast  = l;
            bus.fifoFull = f;
            for (int i = 0; i < c_N; i++) dat[i] = $urandom;
            e_ready = '0;
            e_push  = 1'b0;
            e_data  = '0;
            if (m_owner >= 0 && !f) begin
                e_ready = c_N'(1) << m_owner;
                e_push  = bit_of(v, m_owner);
                if (e_push) e_data = dat[m_owner];
            end
            @(negedge clock);
            check("rnd_ready", bus.reqReady, e_ready);
            check("rnd_push", bus.fifoPush, e_push);
            check("rnd_data", bus.fifoData, e_data);
            check("rnd_busy", bus.busy, m_owner >= 0);
            check("rnd_gid", bus.grantId, m_gid);
`ifndef IP_FIFO_ARB_STARVE_EN
            check("rnd_starve", bus.starveErr, 0);
`endif
            @(posedge clock);
            #1;
            if (m_owner < 0) begin
                for (int k = c_N; k >= 1; k--) begin
                    if (bit_of(v, (m_last + k) % c_N)) m_owner = (m_last + k) % c_N;
                end
                if (m_owner >= 0) begin
                    m_gid   = m_owner;
                    m_beats = 0;
                end
            end else if (e_push) begin
                m_beats++;
                if (bit_of(l, m_owner) || m_beats == c_MAXB) begin
                    m_last  = m_owner;
                    m_owner = -1;
                end
            end
        end
    endtask

    initial begin
        int exp_g [$];

        // reset values
        reset        = 1'b1;
        bus.reqValid = '1;
        bus.reqLast  = '0;
        bus.fifoFull = 1'b0;
        for (int i = 0; i < c_N; i++) dat[i] = tag(i, 0);
        repeat (3) @(posedge clock);
        #1;
        check("rst_busy", bus.busy, 0);
        check("rst_ready", bus.reqReady, 0);
        check("rst_push", bus.fifoPush, 0);
        check("rst_data", bus.fifoData, 0);
        check("rst_gid", bus.grantId, 0);
        check("rst_starve", bus.starveErr, 0);

        // single bursts, back-pressure, valid gap, cap+last together, same-owner regrant
        tbl.push_back('{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0});
        tbl.push_back('{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1});
        tbl.push_back('{4'b0010, 4'b0000, 1'b0, 4'b0010, 1'b1, 1'b1, 1});
        tbl.push_back('{4'b0010, 4'b0010, 1'b0, 4'b0010, 1'b1, 1'b1, 1});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 1});
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2});
        for (int k = 0; k < 5; k++)
            tbl.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 2});
        tbl.push_back('{4'b0100, 4'b0000, 1'b0, 4'b0100, 1'b1, 1'b1, 2});
        tbl.push_back('{4'b0100, 4'b0100, 1'b0, 4'b0100, 1'b1, 1'b1, 2});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2});
        tbl.push_back('{4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 2});
        tbl.push_back('{4'b1000, 4'b0000, 1'b0, 4'b1000, 1'b1, 1'b1, 3});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 4'b1000, 1'b0, 1'b1, 3});
        tbl.push_back('{4'b1000, 4'b1000, 1'b0, 4'b1000, 1'b1, 1'b1, 3});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 3});
        tbl.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 3});
        for (int k = 0; k < 3; k++)
            tbl.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 1'b1, 1'b1, 0});
        tbl.push_back('{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0});
        tbl.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0});
        tbl.push_back('{4'b0001, 4'b0001, 1'b0, 4'b0001, 1'b1, 1'b1, 0});
        tbl.push_back('{4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 0});
        do_reset();
        run_table();

        // all four requesters, 2-beat bursts: 0,1,2,3,0 with a bubble between grants
        do_reset();
        for (int i = 0; i < c_N; i++) set_req(i, 1000, 2);
        exp_g.delete();
        for (int c = 0; c < 15; c++) exp_g.push_back((c % 3 == 0) ? -1 : (c / 3) % c_N);
        run_bfm("rr", exp_g);

        // burst cap: req0 sends 10 beats with req2 waiting
        do_reset();
        set_req(0, 10, 100);
        set_req(1, 0, 1);
        set_req(2, 2, 2);
        set_req(3, 0, 1);
        exp_g = '{-1, 0, 0, 0, 0, -1, 2, 2, -1, 0, 0, 0, 0, -1, 0, 0, -1};
        run_bfm("cap", exp_g);

        // reset mid-burst after two beats of a six-beat burst
        do_reset();
        set_req(0, 0, 1);
        set_req(1, 6, 6);
        set_req(2, 0, 1);
        set_req(3, 0, 1);
        exp_g = '{-1, 1, 1};
        run_bfm("pre", exp_g);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        set_req(0, 4, 4);
        set_req(1, 6, 6);
        exp_g = '{-1, 0, 0};
        run_bfm("post", exp_g);

`ifdef IP_FIFO_ARB_STARVE_EN
        // req0 holds the grant under back-pressure while req3 waits
        do_reset();
        bus.fifoFull = 1'b1;
        bus.reqValid = 4'b1001;
        repeat (15) begin
            @(posedge clock);
            #1;
        end
        @(negedge clock);
        check("starve_before", bus.starveErr, 4'b0000);
        @(posedge clock);
        #1;
        @(negedge clock);
        check("starve_rise", bus.starveErr, 4'b1000);
        bus.reqValid = 4'b0000;
        repeat (4) @(posedge clock);
        #1;
        @(negedge clock);
        check("starve_sticky", bus.starveErr, 4'b1000);
        @(posedge clock);
        #1;
`endif

        do_reset();
        run_random(400);

`ifndef IP_FIFO_ARB_STARVE_EN
        check("starve_off", bus.starveErr, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
